ws2812_line_decoder: RTL
========================

# ws2812_line_decoder

Receiver for the single-wire WS2812 LED stream driven on `leds_line`. It samples the line, classifies each high pulse as a 0 or 1 bit, assembles 24-bit GRB pixels MSB-first, and reports each pixel with its position index. It also detects the latch/reset gap that ends a frame. It sits in loopback test builds and on-board monitors, fed from the racer's LED output pin or a tapped strip segment, so pixel traffic can be checked without a physical strip.

## Interface
- `MAX_POS`, 109: index of the last LED accepted; pixels beyond it are dropped.
- `BIT_THRESHOLD_CLK_CNT`, 30: high time ≥ this decodes as 1, below decodes as 0.
- `MIN_HIGH_CLK_CNT`, 8: high time below this is a glitch.
- `RESET_CLK_CNT`, 2500: low time ≥ this ends the frame (50 µs at 50 MHz).
- `IDX_W`, `$clog2(MAX_POS+1)`: width of the index and count outputs.

Ports:
- `clk`  in  1  system clock (50 MHz on DE0-Nano).
- `reset_n`  in  1  asynchronous, active-low reset.
- `leds_line`  in  1  asynchronous WS2812 data line.
- `pixel_valid`  out  1  one-cycle strobe; `pixel_grb` and `pixel_index` are valid.
- `pixel_grb`  out  24  decoded pixel, G[23:16] R[15:8] B[7:0].
- `pixel_index`  out  IDX_W  position of the pixel within the frame, 0-based.
- `frame_done`  out  1  one-cycle strobe at the end of the latch gap.
- `frame_pixel_count`  out  IDX_W+1  number of complete pixels accepted in the last frame; held until the next `frame_done`.
- `frame_error`  out  1  sticky; cleared on `frame_done` of a clean frame.

## Operation
- `leds_line` passes through a 2-FF synchronizer. A rise/fall detector works on the synced value (`s`).
- Counters: `high_cnt` and `low_cnt`, both saturating at `RESET_CLK_CNT`. `bit_cnt` runs 0..23. A 24-bit shift register fills MSB-first. `idx` runs 0..MAX_POS+1.
- **WAIT_GAP** (entered from reset):
  - Counts consecutive `s`=0 cycles. Any 1 clears the count.
  - When the count reaches `RESET_CLK_CNT`, go to IDLE without asserting `frame_done`.
- **IDLE**:
  - Rise on `s`: go to HIGH with `high_cnt`=1.
- **HIGH**:
  - `high_cnt` increments each cycle.
  - Reaching `RESET_CLK_CNT` (stuck high): set `frame_error`, discard the partial pixel, go to WAIT_GAP.
  - Fall on `s`, glitch (`high_cnt` < `MIN_HIGH_CLK_CNT`): set `frame_error`, go to LOW without shifting a bit.
  - Fall on `s`, otherwise: shift in (`high_cnt` ≥ `BIT_THRESHOLD_CLK_CNT`) and go to LOW with `low_cnt`=1.
  - On the 24th bit:
    - If `idx` ≤ `MAX_POS`: load `pixel_grb` and `pixel_index`=`idx`, pulse `pixel_valid`.
    - If `idx` > `MAX_POS`: set `frame_error`, no strobe.
    - In both cases: `bit_cnt`←0 and `idx` increments, saturating at MAX_POS+1.
- **LOW**:
  - Rise on `s`: go to HIGH.
  - `low_cnt` reaches `RESET_CLK_CNT`: pulse `frame_done` and latch `frame_pixel_count` = min(`idx`, MAX_POS+1).
    - A nonzero `bit_cnt` (partial pixel) sets `frame_error` in the same cycle.
    - If no error occurred during the frame, clear `frame_error`.
    - Then clear `idx` and `bit_cnt` and go to IDLE.
- `reset_n` low at any time: all state cleared immediately. Decoding resumes only after a full gap seen in WAIT_GAP.

## Timing
- Reset values:
  - `pixel_valid`=0, `frame_done`=0, `frame_error`=0.
  - `pixel_grb`=0, `pixel_index`=0, `frame_pixel_count`=0.
  - State WAIT_GAP.
- Edge detection lags the pin by 2 cycles (synchronizer). Measured high and low widths equal the pin widths ±1 cycle.
- `pixel_valid` is registered. It asserts 3 cycles after the pin's falling edge of bit 23 and lasts exactly 1 cycle. `pixel_grb` and `pixel_index` hold until the next strobe.
- `frame_done` asserts `RESET_CLK_CNT`+2 cycles after the last pin falling edge and lasts 1 cycle.
- `frame_done` and `pixel_valid` never coincide.
- Minimum accepted bit period: `MIN_HIGH_CLK_CNT`+2 cycles. No backpressure; consumers must accept each strobe.

## Test plan
- **Single pixel:** after a 3000-cycle low, send 0x00FF00. 0 = 20 high/42 low cycles, 1 = 40 high/22 low. Then hold low 3000 cycles → one `pixel_valid` with `pixel_grb`=0x00FF00, `pixel_index`=0; `frame_done` once; `frame_pixel_count`=1; `frame_error`=0.
- **Full frame:** 110 pixels, pixel n = {n, ~n, 8'hA5} → 110 strobes with indices 0..109 and matching data; `frame_pixel_count`=110.
- **Overflow:** 112 pixels → 110 strobes; `frame_error`=1; `frame_pixel_count`=110. A following clean 1-pixel frame → `frame_error` clears at its `frame_done`.
- **Partial pixel and glitch:**
  - 12 bits then a gap → no strobe, `frame_done` with count 0, `frame_error`=1.
  - A 4-cycle high inside a pixel → `frame_error`=1 and the glitch bit is not counted.
- **Stuck high and mid-frame reset:**
  - Hold line high 3000 cycles → `frame_error`=1; no strobe until a gap plus a new pixel.
  - Assert `reset_n` low mid-pixel → all outputs 0 at once; the first pixel decodes only after a 2500-cycle gap.

Source files
------------

// File: rtl/ws2812_line_decoder.sv
// rtl/ws2812_line_decoder.sv - WS2812 single-wire stream receiver
// Decodes GRB pixels from pulse widths and detects the latch gap that ends a frame.
module ws2812_line_decoder #(
  parameter int MAX_POS               = 109,
  parameter int BIT_THRESHOLD_CLK_CNT = 30,
  parameter int MIN_HIGH_CLK_CNT      = 8,
  parameter int RESET_CLK_CNT         = 2500,
  parameter int IDX_W                 = $clog2(MAX_POS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             leds_line,
  output logic             pixel_valid,
  output logic [23:0]      pixel_grb,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic [IDX_W:0]   frame_pixel_count,
  output logic             frame_error
);

  localparam int CNT_W = $clog2(RESET_CLK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(RESET_CLK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MIN_HIGH = CNT_W'(MIN_HIGH_CLK_CNT);
  localparam logic [CNT_W-1:0] CNT_BIT_THR  = CNT_W'(BIT_THRESHOLD_CLK_CNT);
  localparam logic [IDX_W:0]   IDX_ONE      = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   IDX_LAST     = (IDX_W + 1)'(MAX_POS);
  localparam logic [IDX_W:0]   IDX_SAT      = (IDX_W + 1)'(MAX_POS + 1);
  localparam logic [4:0]       BIT_LAST     = 5'd23;

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state, state_d;

  logic s_meta, s, s_prev;
  logic rise, fall;

  logic [CNT_W-1:0] high_cnt, high_cnt_d;
  logic [CNT_W-1:0] low_cnt, low_cnt_d;
  logic [4:0]       bit_cnt, bit_cnt_d;
  logic [23:0]      shreg, shreg_d;
  logic [IDX_W:0]   idx, idx_d;
  logic             err_pend, err_pend_d;

  logic             pixel_valid_d;
  logic [23:0]      pixel_grb_d;
  logic [IDX_W-1:0] pixel_index_d;
  logic             frame_done_d;
  logic [IDX_W:0]   frame_pixel_count_d;
  logic             frame_error_d;

  logic             bit_val;
  logic [23:0]      shreg_in;

  assign rise     = s & ~s_prev;
  assign fall     = ~s & s_prev;
  assign bit_val  = (high_cnt >= CNT_BIT_THR);
  assign shreg_in = {shreg[22:0], bit_val};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= leds_line;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= WAIT_GAP;
      high_cnt          <= '0;
      low_cnt           <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      idx               <= '0;
      err_pend          <= 1'b0;
      pixel_valid       <= 1'b0;
      pixel_grb         <= '0;
      pixel_index       <= '0;
      frame_done        <= 1'b0;
      frame_pixel_count <= '0;
      frame_error       <= 1'b0;
    end else begin
      state             <= state_d;
      high_cnt          <= high_cnt_d;
      low_cnt           <= low_cnt_d;
      bit_cnt           <= bit_cnt_d;
      shreg             <= shreg_d;
      idx               <= idx_d;
      err_pend          <= err_pend_d;
      pixel_valid       <= pixel_valid_d;
      pixel_grb         <= pixel_grb_d;
      pixel_index       <= pixel_index_d;
      frame_done        <= frame_done_d;
      frame_pixel_count <= frame_pixel_count_d;
      frame_error       <= frame_error_d;
    end
  end

  always_comb begin
    state_d             = state;
    high_cnt_d          = high_cnt;
    low_cnt_d           = low_cnt;
    bit_cnt_d           = bit_cnt;
    shreg_d             = shreg;
    idx_d               = idx;
    err_pend_d          = err_pend;
    pixel_valid_d       = 1'b0;
    pixel_grb_d         = pixel_grb;
    pixel_index_d       = pixel_index;
    frame_done_d        = 1'b0;
    frame_pixel_count_d = frame_pixel_count;
    frame_error_d       = frame_error;

    unique case (state)
      WAIT_GAP: begin
        // The gap must be uninterrupted; decoding starts fresh after it.
        if (s) begin
          low_cnt_d = '0;
        end else if (low_cnt == CNT_LAST) begin
          low_cnt_d  = '0;
          idx_d      = '0;
          bit_cnt_d  = '0;
          err_pend_d = 1'b0;
          state_d    = IDLE;
        end else begin
          low_cnt_d = low_cnt + CNT_ONE;
        end
      end

      IDLE: begin
        if (rise) begin
          high_cnt_d = CNT_ONE;
          state_d    = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          if (high_cnt < CNT_MIN_HIGH) begin
            frame_error_d = 1'b1;
            err_pend_d    = 1'b1;
          end else begin
            shreg_d = shreg_in;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_d = '0;
              if (idx <= IDX_LAST) begin
                pixel_valid_d = 1'b1;
                pixel_grb_d   = shreg_in;
                pixel_index_d = idx[IDX_W-1:0];
              end else begin
                frame_error_d = 1'b1;
                err_pend_d    = 1'b1;
              end
              if (idx != IDX_SAT) begin
                idx_d = idx + IDX_ONE;
              end
            end else begin
              bit_cnt_d = bit_cnt + 5'd1;
            end
          end
          low_cnt_d = CNT_ONE;
          state_d   = LOW;
        end else if (high_cnt == CNT_LAST) begin
          // Stuck high: drop the frame and resynchronise on a fresh gap.
          frame_error_d = 1'b1;
          bit_cnt_d     = '0;
          idx_d         = '0;
          low_cnt_d     = '0;
          state_d       = WAIT_GAP;
        end else begin
          high_cnt_d = high_cnt + CNT_ONE;
        end
      end

      LOW: begin
        if (rise) begin
          high_cnt_d = CNT_ONE;
          state_d    = HIGH;
        end else if (low_cnt == CNT_LAST) begin
          frame_done_d        = 1'b1;
          frame_pixel_count_d = idx;
          frame_error_d       = err_pend | (bit_cnt != 5'd0);
          idx_d               = '0;
          bit_cnt_d           = '0;
          err_pend_d          = 1'b0;
          low_cnt_d           = '0;
          state_d             = IDLE;
        end else begin
          low_cnt_d = low_cnt + CNT_ONE;
        end
      end

      default: state_d = WAIT_GAP;
    endcase
  end

endmodule
